// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and helpers for the BRAM port arbiter: FSM state encoding and
// the modulo-increment used to advance the round-robin pointers.
package bram_arb_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side and BRAM-side signals of the arbiter; slave = arbiter,
// master = requesters plus the BRAM instance.
interface bram_port_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 8
);

  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ-1:0]            i_req_write;
  logic [NUM_REQ*ADDR_W-1:0]     i_req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic [NUM_REQ-1:0]            o_rsp_valid;
  logic [DATA_WIDTH-1:0]         o_rsp_data;
  logic                          o_init_done;
  logic                          o_bram_write;
  logic                          o_bram_read;
  logic [ADDR_W-1:0]             o_bram_wrt_addr;
  logic [ADDR_W-1:0]             o_bram_read_addr;
  logic [DATA_WIDTH-1:0]         o_bram_data;
  logic [DATA_WIDTH-1:0]         i_bram_data;

  modport slave (
    input  i_req_valid, i_req_write, i_req_addr, i_req_data, i_bram_data,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_init_done,
           o_bram_write, o_bram_read, o_bram_wrt_addr, o_bram_read_addr, o_bram_data
  );

  modport master (
    output i_req_valid, i_req_write, i_req_addr, i_req_data, i_bram_data,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_init_done,
           o_bram_write, o_bram_read, o_bram_wrt_addr, o_bram_read_addr, o_bram_data
  );

endinterface

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// Round-robin picker: first requester at or after ptr (wrapping) wins.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner,
  output logic               found
);

  int              idx;
  logic [ID_W-1:0] sel;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = ID_W'(idx);
      if (!found && req[sel]) begin
        found      = 1'b1;
        winner     = sel;
        grant[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one simple-dual-port BRAM between NUM_REQ requesters: zero-fills the
// RAM after reset, then round-robins the write and read ports independently.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int RAM_DEPTH    = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  bram_port_arbiter_if.slave  bus
);

  localparam int ADDR_W = $clog2(RAM_DEPTH);
  localparam int ID_W   = $clog2(NUM_REQ);

  state_e                  state;
  logic [ADDR_W-1:0]       init_cnt;
  logic                    init_done_q;
  logic [ID_W-1:0]         wptr, rptr, wwin, rwin;
  logic [NUM_REQ-1:0]      wcand, rcand, wgnt_raw, rgnt_raw;
  logic                    wany, rany, live, collide, wr_go, rd_go, init_wr;
  logic [ADDR_W-1:0]       req_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0]   req_data [NUM_REQ];
  logic                    rsp_vld_p [READ_LATENCY];
  logic [ID_W-1:0]         rsp_id_p  [READ_LATENCY];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_addr[k] = bus.i_req_addr[k*ADDR_W +: ADDR_W];
    assign req_data[k] = bus.i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // FSM: INIT walks every address once, then RUN until the next reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      init_cnt    <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == ADDR_W'(RAM_DEPTH - 1)) begin
            state       <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN:     init_done_q <= 1'b1;
        default: state <= INIT;
      endcase
    end
  end

  assign wcand = bus.i_req_valid &  bus.i_req_write;
  assign rcand = bus.i_req_valid & ~bus.i_req_write;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_warb (
    .req(wcand), .ptr(wptr), .grant(wgnt_raw), .winner(wwin), .found(wany)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rarb (
    .req(rcand), .ptr(rptr), .grant(rgnt_raw), .winner(rwin), .found(rany)
  );

  // Outputs are also masked while rst is high so nothing leaks in the reset cycle
  assign live    = init_done_q && !rst;
  assign init_wr = (state == INIT) && !rst;
  // A same-address read yields to the write and retries, so it observes the new data
  assign collide = wany && rany && (req_addr[wwin] == req_addr[rwin]);
  assign wr_go   = live && wany;
  assign rd_go   = live && rany && !collide;

  assign bus.o_req_ready      = (wr_go ? wgnt_raw : '0) | (rd_go ? rgnt_raw : '0);
  assign bus.o_bram_write     = init_wr || wr_go;
  assign bus.o_bram_wrt_addr  = (state == INIT) ? init_cnt : req_addr[wwin];
  assign bus.o_bram_data      = (state == INIT) ? '0 : req_data[wwin];
  assign bus.o_bram_read      = rd_go;
  assign bus.o_bram_read_addr = req_addr[rwin];
  assign bus.o_init_done      = init_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_go) wptr <= ID_W'(rr_next(32'(wwin), NUM_REQ));
      if (rd_go) rptr <= ID_W'(rr_next(32'(rwin), NUM_REQ));
    end
  end

  // Tag pipeline p0..p(READ_LATENCY-1): valid is flushed on reset, id is not
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) rsp_vld_p[i] <= 1'b0;
    end else begin
      rsp_vld_p[0] <= rd_go;
      for (int i = 1; i < READ_LATENCY; i++) rsp_vld_p[i] <= rsp_vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    rsp_id_p[0] <= rwin;
    for (int i = 1; i < READ_LATENCY; i++) rsp_id_p[i] <= rsp_id_p[i-1];
  end

  always_comb begin
    bus.o_rsp_valid = '0;
    if (rsp_vld_p[READ_LATENCY-1] && !rst) bus.o_rsp_valid[rsp_id_p[READ_LATENCY-1]] = 1'b1;
  end

  assign bus.o_rsp_data = bus.i_bram_data;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter with a behavioural registered-read BRAM,
// NUM_REQ=4, RAM_DEPTH=256, READ_LATENCY=1.
module tb_bram_port_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int AW   = 8;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  bram_port_arbiter_if #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

  bram_port_arbiter #(
    .NUM_REQ(NREQ), .DATA_WIDTH(DW), .RAM_DEPTH(256), .READ_LATENCY(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM starts filled with a non-zero pattern so the zero-fill is observable
  logic [DW-1:0] mem [256];
  logic          poison;

  always @(posedge clk) begin
    if (poison) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_A5A5;
    end else if (bus.o_bram_write) begin
      mem[bus.o_bram_wrt_addr] <= bus.o_bram_data;
    end
    if (bus.o_bram_read) bus.i_bram_data <= mem[bus.o_bram_read_addr];
  end

  typedef struct {
    logic [3:0]   valid;
    logic [3:0]   write;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [3:0]   exp_ready;
    logic         exp_wr;
    logic         exp_rd;
    logic [3:0]   exp_rsp;
    logic [31:0]  exp_rdata;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] w, input logic [31:0] a,
                              input logic [127:0] d, input logic [3:0] rdy, input logic wr,
                              input logic rd, input logic [3:0] rv, input logic [31:0] rdat);
    vec_t r;
    r.valid = v;  r.write = w;  r.addr = a;  r.data = d;
    r.exp_ready = rdy;  r.exp_wr = wr;  r.exp_rd = rd;  r.exp_rsp = rv;  r.exp_rdata = rdat;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] w, input logic [31:0] a,
                       input logic [127:0] d);
    bus.i_req_valid = v;
    bus.i_req_write = w;
    bus.i_req_addr  = a;
    bus.i_req_data  = d;
  endtask

  // Counts rising edges after reset release until o_init_done is seen high
  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (bus.o_init_done !== 1'b1 && n < 400) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n == 100) begin
        #1;
        check({name, " ready held in INIT"}, 32'(bus.o_req_ready), 32'h0);
        check({name, " zero-fill strobe"}, {31'h0, bus.o_bram_write}, 32'h1);
        check({name, " zero-fill data"}, bus.o_bram_data, 32'h0);
      end
    end
    check({name, " init cycles"}, n, 256);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    poison = 1'b1;
    drive(4'b0000, 4'b0000, 32'h0, 128'h0);

    // Row layout: valid, write, {a3,a2,a1,a0}, {d3,d2,d1,d0}, ready, bram_wr, bram_rd, rsp_valid, rsp_data
    tbl[0]  = mk(4'b0001, 4'b0000, 32'h0000_007F, 128'h0, 4'b0001, 0, 1, 4'b0000, 32'h0);
    tbl[1]  = mk(4'b0001, 4'b0001, 32'h0000_0005, {96'h0, 32'hDEAD_BEEF},
                 4'b0001, 1, 0, 4'b0001, 32'h0);
    tbl[2]  = mk(4'b0010, 4'b0000, 32'h0000_0500, 128'h0, 4'b0010, 0, 1, 4'b0000, 32'h0);
    tbl[3]  = mk(4'b1111, 4'b1111, 32'h2322_2120,
                 {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000},
                 4'b0010, 1, 0, 4'b0010, 32'hDEAD_BEEF);
    tbl[4]  = mk(4'b1111, 4'b1111, 32'h2322_2120,
                 {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000},
                 4'b0100, 1, 0, 4'b0000, 32'h0);
    tbl[5]  = mk(4'b1111, 4'b1111, 32'h2322_2120,
                 {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000},
                 4'b1000, 1, 0, 4'b0000, 32'h0);
    tbl[6]  = mk(4'b0001, 4'b0001, 32'h2322_2120,
                 {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000},
                 4'b0001, 1, 0, 4'b0000, 32'h0);
    tbl[7]  = mk(4'b1000, 4'b0000, 32'h2300_0000, 128'h0, 4'b1000, 0, 1, 4'b0000, 32'h0);
    tbl[8]  = mk(4'b1111, 4'b0000, 32'h2322_2120, 128'h0, 4'b0001, 0, 1, 4'b1000, 32'h1000_0003);
    tbl[9]  = mk(4'b1111, 4'b0000, 32'h2322_2120, 128'h0, 4'b0010, 0, 1, 4'b0001, 32'h1000_0000);
    tbl[10] = mk(4'b1111, 4'b0000, 32'h2322_2120, 128'h0, 4'b0100, 0, 1, 4'b0010, 32'h1000_0001);
    tbl[11] = mk(4'b1111, 4'b0000, 32'h2322_2120, 128'h0, 4'b1000, 0, 1, 4'b0100, 32'h1000_0002);
    tbl[12] = mk(4'b1111, 4'b0000, 32'h2322_2120, 128'h0, 4'b0001, 0, 1, 4'b1000, 32'h1000_0003);
    tbl[13] = mk(4'b0000, 4'b0000, 32'h0, 128'h0, 4'b0000, 0, 0, 4'b0001, 32'h1000_0000);
    tbl[14] = mk(4'b1100, 4'b0100, 32'h0909_0000, {32'h0, 32'h0000_0055, 64'h0},
                 4'b0100, 1, 0, 4'b0000, 32'h0);
    tbl[15] = mk(4'b1000, 4'b0000, 32'h0900_0000, 128'h0, 4'b1000, 0, 1, 4'b0000, 32'h0);
    tbl[16] = mk(4'b0000, 4'b0000, 32'h0, 128'h0, 4'b0000, 0, 0, 4'b1000, 32'h0000_0055);
    tbl[17] = mk(4'b0011, 4'b0001, 32'h0000_0403, {96'h0, 32'hCAFE_0003},
                 4'b0011, 1, 1, 4'b0000, 32'h0);
    tbl[18] = mk(4'b0000, 4'b0000, 32'h0, 128'h0, 4'b0000, 0, 0, 4'b0010, 32'h0);
    tbl[19] = mk(4'b0100, 4'b0100, 32'h00FF_0000, {32'h0, 32'h0BAD_F00D, 64'h0},
                 4'b0100, 1, 0, 4'b0000, 32'h0);
    tbl[20] = mk(4'b0100, 4'b0000, 32'h00FF_0000, 128'h0, 4'b0100, 0, 1, 4'b0000, 32'h0);
    tbl[21] = mk(4'b0000, 4'b0000, 32'h0, 128'h0, 4'b0000, 0, 0, 4'b0100, 32'h0BAD_F00D);
    tbl[22] = mk(4'b0010, 4'b0000, 32'h0000_0300, 128'h0, 4'b0010, 0, 1, 4'b0000, 32'h0);
    tbl[23] = mk(4'b0000, 4'b0000, 32'h0, 128'h0, 4'b0000, 0, 0, 4'b0010, 32'hCAFE_0003);

    @(posedge clk);
    @(negedge clk);
    poison = 1'b0;
    @(negedge clk);
    #1;
    check("reset ready", 32'(bus.o_req_ready), 32'h0);
    check("reset rsp_valid", 32'(bus.o_rsp_valid), 32'h0);
    check("reset init_done", {31'h0, bus.o_init_done}, 32'h0);
    check("reset bram_write", {31'h0, bus.o_bram_write}, 32'h0);
    check("reset bram_read", {31'h0, bus.o_bram_read}, 32'h0);

    // Release reset with a read already pending; it must be held off until init completes
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0001, 4'b0000, 32'h0000_007F, 128'h0);
    wait_init("init1");
    drive(4'b0000, 4'b0000, 32'h0, 128'h0);

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].valid, tbl[i].write, tbl[i].addr, tbl[i].data);
      #1;
      check($sformatf("row%0d ready", i), 32'(bus.o_req_ready), 32'(tbl[i].exp_ready));
      check($sformatf("row%0d bram_write", i), {31'h0, bus.o_bram_write}, {31'h0, tbl[i].exp_wr});
      check($sformatf("row%0d bram_read", i), {31'h0, bus.o_bram_read}, {31'h0, tbl[i].exp_rd});
      check($sformatf("row%0d rsp_valid", i), 32'(bus.o_rsp_valid), 32'(tbl[i].exp_rsp));
      if (tbl[i].exp_rsp != 4'b0000)
        check($sformatf("row%0d rsp_data", i), bus.o_rsp_data, tbl[i].exp_rdata);
      @(negedge clk);
    end

    // Reset lands the cycle after a read grant: the in-flight response must vanish
    drive(4'b0001, 4'b0000, 32'h0000_0005, 128'h0);
    #1;
    check("rst-flush read grant", 32'(bus.o_req_ready), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 32'h0, 128'h0);
    #1;
    check("rst-flush rsp cycle1", 32'(bus.o_rsp_valid), 32'h0);
    @(negedge clk);
    #1;
    check("rst-flush rsp cycle2", 32'(bus.o_rsp_valid), 32'h0);
    check("rst-flush init_done", {31'h0, bus.o_init_done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_init("init2");

    drive(4'b0010, 4'b0000, 32'h0000_0500, 128'h0);
    #1;
    check("rezero read5 grant", 32'(bus.o_req_ready), 32'h2);
    @(negedge clk);
    drive(4'b0100, 4'b0000, 32'h0022_0000, 128'h0);
    #1;
    check("rezero read5 rsp_valid", 32'(bus.o_rsp_valid), 32'h2);
    check("rezero read5 data", bus.o_rsp_data, 32'h0);
    check("rezero read22 grant", 32'(bus.o_req_ready), 32'h4);
    @(negedge clk);
    drive(4'b0000, 4'b0000, 32'h0, 128'h0);
    #1;
    check("rezero read22 rsp_valid", 32'(bus.o_rsp_valid), 32'h4);
    check("rezero read22 data", bus.o_rsp_data, 32'h0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
